// File: rtl/operand_read.sv
// ---------------------------------------------------------------------------
// operand_read
//   Reads an A/B operand pair from an 8-entry register file over two cycles
//   (A first, then B) and holds the pair until the downstream stage takes it.
//   A register-file write in the same cycle as a read of that register is
//   bypassed, so the operand always sees the newest value.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   req_valid/req_ready    request handshake (readnum_a/readnum_b captured)
//   readnum_a, readnum_b   register numbers for operands A and B
//   reg0..reg7             current register file contents
//   write, writenum,
//   write_data             register file write port, observed for bypass
//   A_out, B_out           operand pair (registered)
//   out_valid/out_ready    result handshake; out_valid high only in HOLD
//   busy                   high in every state except IDLE
// ---------------------------------------------------------------------------
module operand_read #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       readnum_a,
    input  logic [2:0]       readnum_b,
    input  logic [WIDTH-1:0] reg0,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic [WIDTH-1:0] reg3,
    input  logic [WIDTH-1:0] reg4,
    input  logic [WIDTH-1:0] reg5,
    input  logic [WIDTH-1:0] reg6,
    input  logic [WIDTH-1:0] reg7,
    input  logic             write,
    input  logic [2:0]       writenum,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, READ_A, READ_B, HOLD} state_t;

    state_t           state_q;
    logic [2:0]       num_a_q, num_b_q;
    logic [WIDTH-1:0] a_q, b_q;

    logic [WIDTH-1:0] regs [8];
    logic [2:0]       rd_num;
    logic [WIDTH-1:0] rd_data_d;
    logic             accept;

    assign regs[0] = reg0;
    assign regs[1] = reg1;
    assign regs[2] = reg2;
    assign regs[3] = reg3;
    assign regs[4] = reg4;
    assign regs[5] = reg5;
    assign regs[6] = reg6;
    assign regs[7] = reg7;

    // A new request may start from IDLE, or from HOLD in the same cycle the
    // current pair is consumed (one pair every three cycles).
    assign req_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept    = req_valid && req_ready;

    // One shared read port: READ_A uses the A number, READ_B the B number.
    // The mux value is only loaded in those two states.
    assign rd_num    = (state_q == READ_A) ? num_a_q : num_b_q;
    assign rd_data_d = (write && (writenum == rd_num)) ? write_data : regs[rd_num];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            num_a_q <= '0;
            num_b_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        num_a_q <= readnum_a;
                        num_b_q <= readnum_b;
                        state_q <= READ_A;
                    end
                end
                READ_A: begin
                    a_q     <= rd_data_d;
                    state_q <= READ_B;
                end
                READ_B: begin
                    b_q     <= rd_data_d;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        if (req_valid) begin
                            num_a_q <= readnum_a;
                            num_b_q <= readnum_b;
                            state_q <= READ_A;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign A_out     = a_q;
    assign B_out     = b_q;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_operand_read.sv
module tb_operand_read;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  readnum_a, readnum_b;
    logic [15:0] r [8];
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] write_data;
    logic [15:0] A_out, B_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    operand_read #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .readnum_a(readnum_a), .readnum_b(readnum_b),
        .reg0(r[0]), .reg1(r[1]), .reg2(r[2]), .reg3(r[3]),
        .reg4(r[4]), .reg5(r[5]), .reg6(r[6]), .reg7(r[7]),
        .write(write), .writenum(writenum), .write_data(write_data),
        .A_out(A_out), .B_out(B_out),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (A_out !== 16'h0)    begin errors++; $display("FAIL rst_A got %h exp 0000", A_out); end
        checks++; if (B_out !== 16'h0)    begin errors++; $display("FAIL rst_B got %h exp 0000", B_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_basic();
        req_valid = 1'b1; readnum_a = 3'd3; readnum_b = 3'd5; out_ready = 1'b1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", req_ready); end
        tick();
        req_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_ra valid=%b busy=%b exp 0/1", out_valid, busy); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL basic_ra_ready got %b exp 0", req_ready); end
        tick();
        checks++; if (A_out !== 16'h1234 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_A got %h/%b exp 1234/0", A_out, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
        checks++; if (A_out !== 16'h1234 || B_out !== 16'hABCD) begin errors++; $display("FAIL basic_pair got %h %h exp 1234 abcd", A_out, B_out); end
        tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle valid=%b busy=%b exp 0/0", out_valid, busy); end
        checks++; if (A_out !== 16'h1234 || B_out !== 16'hABCD) begin errors++; $display("FAIL basic_retain got %h %h exp 1234 abcd", A_out, B_out); end
    endtask

    task automatic test_bypass();
        // Same register for A and B; write to it only during READ_B.
        req_valid = 1'b1; readnum_a = 3'd2; readnum_b = 3'd2; out_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        checks++; if (A_out !== 16'h0007) begin errors++; $display("FAIL byp_A got %h exp 0007", A_out); end
        write = 1'b1; writenum = 3'd2; write_data = 16'h0099;
        tick();
        write = 1'b0;
        checks++; if (A_out !== 16'h0007 || B_out !== 16'h0099) begin errors++; $display("FAIL byp_pair got %h %h exp 0007 0099", A_out, B_out); end
        tick();
        // Bypass on A only, non-matching write during READ_B.
        req_valid = 1'b1; readnum_a = 3'd4; readnum_b = 3'd6;
        tick();
        req_valid = 1'b0;
        write = 1'b1; writenum = 3'd4; write_data = 16'h5A5A;
        tick();
        writenum = 3'd1; write_data = 16'hDEAD;
        tick();
        write = 1'b0;
        checks++; if (A_out !== 16'h5A5A || B_out !== 16'h6666) begin errors++; $display("FAIL byp_a_pair got %h %h exp 5a5a 6666", A_out, B_out); end
        tick();
    endtask

    task automatic test_hold();
        req_valid = 1'b1; readnum_a = 3'd6; readnum_b = 3'd7; out_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        write = 1'b1; writenum = 3'd6; write_data = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || A_out !== 16'h6666 || B_out !== 16'h7777 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d got v=%b A=%h B=%h rdy=%b exp 1 6666 7777 0", i, out_valid, A_out, B_out, req_ready);
            end
            tick();
        end
        write = 1'b0;
        checks++; if (out_valid !== 1'b1 || A_out !== 16'h6666) begin errors++; $display("FAIL hold_end got v=%b A=%h exp 1 6666", out_valid, A_out); end
        out_ready = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_exit busy=%b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; readnum_a = 3'd3; readnum_b = 3'd5; out_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got %b exp 1", out_valid); end
        req_valid = 1'b1; readnum_a = 3'd1; readnum_b = 3'd0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", req_ready); end
        tick();
        req_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_ra v=%b busy=%b exp 0/1", out_valid, busy); end
        tick();
        checks++; if (A_out !== 16'h1111 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_A got %h/%b exp 1111/0", A_out, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || A_out !== 16'h1111 || B_out !== 16'h0C00) begin errors++; $display("FAIL b2b_pair got %b %h %h exp 1 1111 0c00", out_valid, A_out, B_out); end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        req_valid = 1'b1; readnum_a = 3'd3; readnum_b = 3'd5; out_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        checks++; if (A_out !== 16'h1234) begin errors++; $display("FAIL rmid_A got %h exp 1234", A_out); end
        #2 reset = 1'b1;
        #1;
        checks++; if (A_out !== 16'h0 || B_out !== 16'h0 || out_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rmid_async got A=%h B=%h v=%b rdy=%b busy=%b exp 0 0 0 1 0", A_out, B_out, out_valid, req_ready, busy);
        end
        tick();
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rmid_novalid got %0d valid cycles exp 0", seen); end
        // First edge after release accepts a request.
        @(negedge clk);
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b1; readnum_a = 3'd7; readnum_b = 3'd4;
        tick();
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rrel_accept busy=%b exp 1", busy); end
        tick();
        tick();
        checks++; if (out_valid !== 1'b1 || A_out !== 16'h7777 || B_out !== 16'h4444) begin errors++; $display("FAIL rrel_pair got %b %h %h exp 1 7777 4444", out_valid, A_out, B_out); end
        tick();
    endtask

    task automatic test_ignore();
        req_valid = 1'b1; readnum_a = 3'd3; readnum_b = 3'd5; out_ready = 1'b1;
        tick();
        readnum_a = 3'd1; readnum_b = 3'd0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ign_ready got %b exp 0", req_ready); end
        tick();
        checks++; if (A_out !== 16'h1234) begin errors++; $display("FAIL ign_A got %h exp 1234", A_out); end
        tick();
        req_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || B_out !== 16'hABCD) begin errors++; $display("FAIL ign_B got %b %h exp 1 abcd", out_valid, B_out); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle busy=%b exp 0", busy); end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; readnum_a = '0; readnum_b = '0;
        write = 1'b0; writenum = '0; write_data = '0; out_ready = 1'b0;
        r[0] = 16'h0C00; r[1] = 16'h1111; r[2] = 16'h0007; r[3] = 16'h1234;
        r[4] = 16'h4444; r[5] = 16'hABCD; r[6] = 16'h6666; r[7] = 16'h7777;
        test_reset();
        test_basic();
        test_bypass();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
